sdram_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port `sdram` core's valid/ready interface.
- Requester 0 is the picorv32 data path.
- Requester 1 is a secondary master, such as a DMA or a future video fetch.
- The block owns the SDRAM handshake: assert valid, wait for ready, drop valid, wait for ready low, then complete. Each requester sees a simple picorv32-style valid/ready bus.

---
 rtl/sdram_arb_pkg.sv | 30 +++
 rtl/sdram_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter: FSM states,
// request bundle, timeout read data and the round-robin pick.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RELEASE,
      DONE
   } arb_state_t;

   localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // addr is sized for the widest core; the top truncates to ADDR_W
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   // returns the winning requester index (0 or 1)
   function automatic logic rr_pick(
      input logic v0,
      input logic v1,
      input logic last
   );
      return (v0 && v1) ? ~last : v1;
   endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter and valid/ready sequencer in front of the sdram core.
// Define SDRAM_ARB_TIMEOUT_EN to enable the watchdog and sticky arb_err.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W         = 25,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wmask,
   output logic              m0_ready,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wmask,
   output logic              m1_ready,
   output logic [31:0]       m1_rdata,
   output logic              sdram_valid,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [31:0]       sdram_din,
   output logic [3:0]        sdram_wmask,
   input  logic              sdram_ready,
   input  logic [31:0]       sdram_dout,
   output logic              arb_err
);

   arb_state_t        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              is_rd_q, is_rd_d;
   logic              sv_q, sv_d;
   logic [ADDR_W-1:0] sa_q, sa_d;
   logic [31:0]       sd_q, sd_d;
   logic [3:0]        sm_q, sm_d;
   logic              rdy0_q, rdy0_d;
   logic              rdy1_q, rdy1_d;
   logic [31:0]       rd0_q, rd0_d;
   logic [31:0]       rd1_q, rd1_d;

   req_t r0, r1, req;
   logic pick;

   assign r0   = '{addr: 32'(m0_addr), wdata: m0_wdata, wmask: m0_wmask};
   assign r1   = '{addr: 32'(m1_addr), wdata: m1_wdata, wmask: m1_wmask};
   assign pick = rr_pick(m0_valid, m1_valid, last_q);
   assign req  = pick ? r1 : r0;

`ifdef SDRAM_ARB_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;
`else
   logic unused_tmo;
   assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      is_rd_d = is_rd_q;
      sv_d    = sv_q;
      sa_d    = sa_q;
      sd_d    = sd_q;
      sm_d    = sm_q;
      rdy0_d  = 1'b0;
      rdy1_d  = 1'b0;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!sdram_ready && (m0_valid || m1_valid)) begin
               grant_d = pick;
               sa_d    = {req.addr[ADDR_W-1:2], 2'b00};
               sd_d    = req.wdata;
               sm_d    = req.wmask;
               is_rd_d = (req.wmask == 4'b0000);
               sv_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (sdram_ready) begin
               if (is_rd_q) begin
                  if (grant_q) rd1_d = sdram_dout;
                  else         rd0_d = sdram_dout;
               end
               sv_d    = 1'b0;
               sm_d    = 4'b0000;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!sdram_ready) begin
               rdy0_d  = ~grant_q;
               rdy1_d  = grant_q;
               last_d  = grant_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef SDRAM_ARB_TIMEOUT_EN
      // watchdog overrides whatever the handshake decided this cycle
      if (state_q == ISSUE || state_q == RELEASE) begin
         cnt_d = cnt_q + 32'd1;
         if (cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            sv_d = 1'b0;
            sm_d = 4'b0000;
            if (is_rd_q) begin
               if (grant_q) rd1_d = ARB_TIMEOUT_DATA;
               else         rd0_d = ARB_TIMEOUT_DATA;
            end
            rdy0_d  = ~grant_q;
            rdy1_d  = grant_q;
            last_d  = grant_q;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         is_rd_q <= 1'b0;
         sv_q    <= 1'b0;
         sa_q    <= '0;
         sd_q    <= '0;
         sm_q    <= '0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         is_rd_q <= is_rd_d;
         sv_q    <= sv_d;
         sa_q    <= sa_d;
         sd_q    <= sd_d;
         sm_q    <= sm_d;
         rdy0_q  <= rdy0_d;
         rdy1_q  <= rdy1_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign arb_err = err_q;
`else
   assign arb_err = 1'b0;
`endif

   assign sdram_valid = sv_q;
   assign sdram_addr  = sa_q;
   assign sdram_din   = sd_q;
   assign sdram_wmask = sm_q;
   assign m0_ready    = rdy0_q;
   assign m1_ready    = rdy1_q;
   assign m0_rdata    = rd0_q;
   assign m1_rdata    = rd1_q;

endmodule
